// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel byte-serial memory controller.
//
// Arbitrates NUM_CH requesters round-robin onto an 8-bit RAM/IO bus and moves
// 1..MAX_BYTES bytes per transfer. Writes issue one byte per cycle and stall
// on a full IO buffer. Reads issue one address per cycle and capture the byte
// returned one cycle later. A rollback pulse aborts reads on RB_MASK channels.
//
// Handshake: req_valid_i[c] is raised with req_wr/addr/len/wdata for channel c
// stable and held until done_o[c] pulses; the requester drops req_valid_i[c]
// in that done cycle, because that cycle is already IDLE and may grant again.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   rdy_i            0 freezes every register; ram_rw_sel_o forced to 0
//   rb_i             rollback pulse
//   io_full_i        IO (uart) buffer full
//   req_*_i          per-channel request: valid, wr, addr, len, wdata
//   done_o           one-hot, one-cycle completion pulse
//   rdata_o          read data, valid with done_o; unread upper bytes zero
//   ram_addr_o, ram_wr_byte_o, ram_rw_sel_o   bus outputs (1 = write)
//   ram_rd_byte_i    read byte, one cycle after the address
//   dbg_state_o      current FSM state (0 IDLE, 1 READ, 2 WRITE)
module mem_arbiter #(
  parameter int                NUM_CH    = 3,
  parameter int                MAX_BYTES = 16,
  parameter int                LEN_W     = 5,
  parameter logic [NUM_CH-1:0] RB_MASK   = 3'b010
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rdy_i,
  input  logic                          rb_i,
  input  logic                          io_full_i,
  input  logic [NUM_CH-1:0]             req_valid_i,
  input  logic [NUM_CH-1:0]             req_wr_i,
  input  logic [NUM_CH*32-1:0]          req_addr_i,
  input  logic [NUM_CH*LEN_W-1:0]       req_len_i,
  input  logic [NUM_CH*MAX_BYTES*8-1:0] req_wdata_i,
  output logic [NUM_CH-1:0]             done_o,
  output logic [MAX_BYTES*8-1:0]        rdata_o,
  output logic [31:0]                   ram_addr_o,
  output logic [7:0]                    ram_wr_byte_o,
  input  logic [7:0]                    ram_rd_byte_i,
  output logic                          ram_rw_sel_o,
  output logic [1:0]                    dbg_state_o
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW   = MAX_BYTES * 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d, rr_ptr_q, rr_ptr_d;
  logic [31:0]        base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic [DW-1:0]      wdata_q, wdata_d, buf_q, buf_d;
  logic [NUM_CH-1:0]  done_q, done_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [31:0]        ram_addr_q, ram_addr_d;
  logic [7:0]         ram_wr_byte_q, ram_wr_byte_d;
  logic               ram_rw_sel_q, ram_rw_sel_d;

  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] p, input int i);
    int s;
    s = (int'(p) + i) % NUM_CH;
    return CH_W'(s);
  endfunction

  // Round-robin: scan from farthest to nearest so the nearest eligible
  // channel after rr_ptr_q overwrites any earlier hit.
  logic [NUM_CH-1:0] eligible;
  logic              grant_found;
  logic [CH_W-1:0]   grant_ch;
  always_comb begin
    eligible    = req_valid_i & ~(rb_i ? RB_MASK : {NUM_CH{1'b0}});
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (eligible[wrap_add(rr_ptr_q, i)]) begin
        grant_found = 1'b1;
        grant_ch    = wrap_add(rr_ptr_q, i);
      end
    end
  end

  logic [31:0]      byte_addr;
  logic             issuing, io_stall, abort, last_cap;
  logic [7:0]       cur_wbyte;
  logic [LEN_W-1:0] cap_idx;
  always_comb begin
    byte_addr = base_q + 32'(cnt_q);
    issuing   = (cnt_q < len_q);
    io_stall  = (byte_addr[17:16] == 2'b11) && io_full_i;
    abort     = rb_i && RB_MASK[ch_q];
    // Reads run two cycles past the last address: one for the RAM latency,
    // one to capture the final byte.
    last_cap  = (cnt_q == (len_q + LEN_W'(1)));
    cur_wbyte = 8'(wdata_q >> {cnt_q, 3'b000});
    cap_idx   = cnt_q - LEN_W'(2);
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i)      state_q <= S_IDLE;
    else if (rdy_i) state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant_found) state_d = req_wr_i[grant_ch] ? S_WRITE : S_READ;
      S_WRITE: if (!issuing) state_d = S_IDLE;
      S_READ:  if (abort || last_cap) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    ch_d          = ch_q;
    rr_ptr_d      = rr_ptr_q;
    base_d        = base_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    wdata_d       = wdata_q;
    buf_d         = buf_q;
    done_d        = '0;
    rdata_d       = rdata_q;
    ram_addr_d    = '0;
    ram_wr_byte_d = ram_wr_byte_q;
    ram_rw_sel_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          ch_d     = grant_ch;
          rr_ptr_d = grant_ch;
          base_d   = req_addr_i[int'(grant_ch)*32 +: 32];
          len_d    = req_len_i[int'(grant_ch)*LEN_W +: LEN_W];
          wdata_d  = req_wdata_i[int'(grant_ch)*DW +: DW];
          cnt_d    = '0;
          buf_d    = '0;
        end
      end
      S_WRITE: begin
        if (issuing) begin
          ram_addr_d    = byte_addr;
          ram_wr_byte_d = cur_wbyte;
          if (!io_stall) begin
            ram_rw_sel_d = 1'b1;
            cnt_d        = cnt_q + LEN_W'(1);
          end
        end else begin
          done_d = NUM_CH'(1) << ch_q;
        end
      end
      S_READ: begin
        if (!abort) begin
          if (issuing) ram_addr_d = byte_addr;
          if (cnt_q >= LEN_W'(2)) buf_d = buf_q | (DW'(ram_rd_byte_i) << {cap_idx, 3'b000});
          cnt_d = cnt_q + LEN_W'(1);
          if (last_cap) begin
            done_d  = NUM_CH'(1) << ch_q;
            rdata_d = buf_d;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ch_q          <= '0;
      rr_ptr_q      <= CH_W'(NUM_CH - 1);
      base_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      wdata_q       <= '0;
      buf_q         <= '0;
      done_q        <= '0;
      rdata_q       <= '0;
      ram_addr_q    <= '0;
      ram_wr_byte_q <= '0;
      ram_rw_sel_q  <= 1'b0;
    end else if (rdy_i) begin
      ch_q          <= ch_d;
      rr_ptr_q      <= rr_ptr_d;
      base_q        <= base_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      wdata_q       <= wdata_d;
      buf_q         <= buf_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_byte_q <= ram_wr_byte_d;
      ram_rw_sel_q  <= ram_rw_sel_d;
    end
  end

  assign done_o        = done_q;
  assign rdata_o       = rdata_q;
  assign ram_addr_o    = ram_addr_q;
  assign ram_wr_byte_o = ram_wr_byte_q;
  assign ram_rw_sel_o  = ram_rw_sel_q & rdy_i;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table of single transfers checked cycle by cycle
// against hand-computed bus activity, plus hand-written multi-cycle sequences
// for arbitration order, IO stall, rollback and mid-transfer reset.
// The RAM model returns byte value == low address byte, except 0x100..0x103
// which hold 11 22 33 44; it shares the rdy clock enable with the CPU side.
module tb_mem_arbiter;
  localparam int NUM_CH = 3;
  localparam int MAX_BYTES = 16;
  localparam int LEN_W = 5;
  localparam int DW = MAX_BYTES * 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  rdy = 1'b1;
  logic                  rb = 1'b0;
  logic                  io_full = 1'b0;
  logic [NUM_CH-1:0]     req_valid = '0;
  logic [NUM_CH-1:0]     req_wr = '0;
  logic [NUM_CH*32-1:0]  req_addr = '0;
  logic [NUM_CH*LEN_W-1:0] req_len = '0;
  logic [NUM_CH*DW-1:0]  req_wdata = '0;
  logic [NUM_CH-1:0]     done;
  logic [DW-1:0]         rdata;
  logic [31:0]           ram_addr;
  logic [7:0]            ram_wr_byte;
  logic [7:0]            ram_rd_byte = 8'h00;
  logic                  ram_rw_sel;
  logic [1:0]            dbg_state;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.NUM_CH(NUM_CH), .MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W), .RB_MASK(3'b010)) dut (
    .clk_i(clk), .rst_i(rst), .rdy_i(rdy), .rb_i(rb), .io_full_i(io_full),
    .req_valid_i(req_valid), .req_wr_i(req_wr), .req_addr_i(req_addr),
    .req_len_i(req_len), .req_wdata_i(req_wdata), .done_o(done), .rdata_o(rdata),
    .ram_addr_o(ram_addr), .ram_wr_byte_o(ram_wr_byte), .ram_rd_byte_i(ram_rd_byte),
    .ram_rw_sel_o(ram_rw_sel), .dbg_state_o(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // RAM model
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      default: return a[7:0];
    endcase
  endfunction
  always @(posedge clk) if (rdy) ram_rd_byte <= ram_byte(ram_addr);

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {done, rw_sel, addr, byte} e effective edges after the grant edge.
  function automatic logic [43:0] exp_bus(input bit wr, input int ch, input logic [31:0] a,
                                          input int len, input logic [127:0] wd, input int e,
                                          input bit frozen);
    logic [2:0] d; logic rw; logic [31:0] ad; logic [7:0] b;
    d = '0; rw = 1'b0; ad = '0; b = '0;
    if (e >= 1 && e <= len) begin
      ad = a + 32'(e - 1);
      if (wr) begin
        rw = !frozen;
        if (rw) b = wd[8*(e-1) +: 8];
      end
    end
    if (e == (wr ? len + 1 : len + 2)) d = 3'b001 << ch;
    return {d, rw, ad, b};
  endfunction

  task automatic set_req(input int ch, input bit wr, input logic [31:0] a, input int len,
                         input logic [127:0] wd);
    req_wr[ch] = wr;
    req_addr[ch*32 +: 32] = a;
    req_len[ch*LEN_W +: LEN_W] = LEN_W'(len);
    req_wdata[ch*DW +: DW] = wd;
    req_valid[ch] = 1'b1;
  endtask

  // Driver: one transfer from an idle DUT, checked every cycle. Starts and ends at a negedge.
  task automatic run_xfer(input string name, input int ch, input bit wr, input logic [31:0] a,
                          input int len, input logic [127:0] wd, input logic [127:0] exp_rd,
                          input int rb_at, input int stall_at, input int stall_len);
    int e; int fin; int stall_left; bit stalled_once; int n;
    logic [43:0] eb, ab;
    set_req(ch, wr, a, len, wd);
    fin = wr ? len + 1 : len + 2;
    e = 0; stall_left = 0; stalled_once = 0; n = 0;
    @(posedge clk);
    @(negedge clk);
    forever begin
      eb = exp_bus(wr, ch, a, len, wd, e, !rdy);
      ab = {done, ram_rw_sel, ram_addr, eb[40] ? ram_wr_byte : 8'h00};
      check($sformatf("%s bus e=%0d", name, e), 192'(ab), 192'(eb));
      if (e == fin) break;
      rb = (e == rb_at);
      if (!rdy) begin
        stall_left--;
        if (stall_left == 0) rdy = 1'b1;
      end else if (e == stall_at && !stalled_once) begin
        rdy = 1'b0; stall_left = stall_len; stalled_once = 1'b1;
      end
      n++;
      if (n > 200) begin
        check($sformatf("%s timeout", name), 192'(e), 192'(fin));
        break;
      end
      @(posedge clk);
      if (rdy) e++;
      @(negedge clk);
    end
    if (!wr) check($sformatf("%s rdata", name), 192'(rdata), 192'(exp_rd));
    req_valid[ch] = 1'b0;
    rb = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    check($sformatf("%s done pulse", name), 192'(done), 192'(0));
  endtask

  typedef struct {
    int ch; bit wr; logic [31:0] addr; int len; logic [127:0] wd; logic [127:0] rd;
    int rb_at; int st_at; int st_len;
  } vec_t;
  vec_t vecs[10];

  function automatic vec_t mk(int ch, bit wr, logic [31:0] a, int len, logic [127:0] wd,
                              logic [127:0] rd, int rb_at, int st_at, int st_len);
    vec_t v;
    v.ch = ch; v.wr = wr; v.addr = a; v.len = len; v.wd = wd; v.rd = rd;
    v.rb_at = rb_at; v.st_at = st_at; v.st_len = st_len;
    return v;
  endfunction

  // Two requesters competing; completion order goes to the scoreboard queue.
  task automatic arb_test();
    logic [2:0] exp_q[$];
    logic [2:0] exp_d;
    int rem[3];
    bit rearm[3];
    exp_q = '{3'b100, 3'b001, 3'b100, 3'b001};
    rem = '{2, 0, 2};
    rearm = '{0, 0, 0};
    set_req(0, 1'b0, 32'h40, 1, '0);
    set_req(2, 1'b0, 32'h52, 1, '0);
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (rearm[c]) begin req_valid[c] = 1'b1; rearm[c] = 1'b0; end
      end
      if (done != '0) begin
        exp_d = exp_q.pop_front();
        check("arb order", 192'(done), 192'(exp_d));
        check("arb rdata", 192'(rdata), 192'(exp_d == 3'b001 ? 128'h40 : 128'h52));
        for (int c = 0; c < 3; c++) begin
          if (done[c]) begin
            req_valid[c] = 1'b0;
            rem[c]--;
            if (rem[c] > 0) rearm[c] = 1'b1;
          end
        end
      end
    end
    check("arb drained", 192'(exp_q.size()), 192'(0));
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic io_stall_test();
    io_full = 1'b1;
    set_req(2, 1'b1, 32'h30000, 1, 128'h41);
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("io stall k=%0d", k), 192'({done, ram_rw_sel, ram_addr}),
            192'({3'b000, 1'b0, 32'h30000}));
    end
    io_full = 1'b0;
    @(posedge clk); @(negedge clk);
    check("io write", 192'({done, ram_rw_sel, ram_addr, ram_wr_byte}),
          192'({3'b000, 1'b1, 32'h30000, 8'h41}));
    @(posedge clk); @(negedge clk);
    check("io done", 192'({done, ram_rw_sel}), 192'({3'b100, 1'b0}));
    req_valid[2] = 1'b0;
    @(negedge clk);
  endtask

  task automatic rollback_test();
    set_req(1, 1'b0, 32'h100, 4, '0);
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("rb read addr k=%0d", k), 192'({done, ram_addr}),
            192'({3'b000, 32'h100 + 32'(k - 1)}));
    end
    rb = 1'b1;
    req_valid[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    rb = 1'b0;
    check("rb abort", 192'({done, ram_rw_sel, ram_addr, dbg_state}), 192'(0));
    check("rb rdata kept", 192'(rdata), 192'(128'h40));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); @(negedge clk);
      check("rb no done", 192'({done, dbg_state}), 192'(0));
    end
  endtask

  task automatic rb_idle_test();
    bit got;
    got = 1'b0;
    set_req(1, 1'b0, 32'h24, 2, '0);
    rb = 1'b1;
    @(posedge clk); @(negedge clk);
    rb = 1'b0;
    check("rb idle excluded", 192'(dbg_state), 192'(0));
    @(posedge clk); @(negedge clk);
    check("rb idle granted later", 192'(dbg_state), 192'(1));
    for (int n = 0; n < 10 && !got; n++) begin
      @(posedge clk); @(negedge clk);
      if (done != '0) got = 1'b1;
    end
    check("rb idle done", 192'(done), 192'(3'b010));
    check("rb idle rdata", 192'(rdata), 192'(128'h2524));
    req_valid[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_mid_test();
    set_req(0, 1'b1, 32'h300, 8, 128'h8877665544332211);
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre-reset write", 192'({ram_rw_sel, ram_addr}), 192'({1'b1, 32'h302}));
    rst = 1'b1;
    req_valid[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid reset outputs", 192'({done, rdata, ram_addr, ram_wr_byte, ram_rw_sel, dbg_state}),
          192'(0));
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); @(negedge clk);
      check("post reset idle", 192'({done, ram_rw_sel, dbg_state}), 192'(0));
    end
  endtask

  initial begin
    vecs[0] = mk(0, 1'b1, 32'h200, 3, 128'hCCBBAA, '0, -1, -1, 0);
    vecs[1] = mk(2, 1'b0, 32'h20, 3, '0, 128'h222120, -1, -1, 0);
    vecs[2] = mk(0, 1'b0, 32'h1F0, 16, '0, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, -1, -1, 0);
    vecs[3] = mk(1, 1'b1, 32'hFFFFFFFE, 4, 128'h44332211, '0, -1, -1, 0);
    vecs[4] = mk(2, 1'b0, 32'h3C, 1, '0, 128'h3C, -1, -1, 0);
    vecs[5] = mk(2, 1'b1, 32'h30000, 2, 128'h5A41, '0, -1, -1, 0);
    vecs[6] = mk(2, 1'b1, 32'h500, 4, 128'hDDCCBBAA, '0, 2, -1, 0);
    vecs[7] = mk(0, 1'b0, 32'h10, 5, '0, 128'h1413121110, 3, -1, 0);
    vecs[8] = mk(1, 1'b1, 32'h80, 16, 128'hFEDCBA98_76543210_01234567_89ABCDEF, '0, 5, -1, 0);
    vecs[9] = mk(0, 1'b0, 32'h1F0, 16, '0, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, -1, 6, 5);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 192'({done, rdata, ram_addr, ram_wr_byte, ram_rw_sel, dbg_state}),
          192'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", 192'({done, ram_rw_sel, ram_addr, dbg_state}), 192'(0));

    run_xfer("t1 ch1 read", 1, 1'b0, 32'h100, 4, '0, 128'h44332211, -1, -1, 0);
    for (int i = 0; i < 10; i++) begin
      run_xfer($sformatf("vec%0d", i), vecs[i].ch, vecs[i].wr, vecs[i].addr, vecs[i].len,
               vecs[i].wd, vecs[i].rd, vecs[i].rb_at, vecs[i].st_at, vecs[i].st_len);
    end
    arb_test();
    io_stall_test();
    rollback_test();
    run_xfer("after rb ch0 read", 0, 1'b0, 32'h1F0, 16, '0,
             128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, -1, -1, 0);
    rb_idle_test();
    reset_mid_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
